// File: rtl/argmax_top2_if.sv
// Handshake and result bus for argmax_top2: request with packed scores, busy/done,
// and the registered classification results.
interface argmax_top2_if #(
   parameter int WIDTH       = 32,
   parameter int NUM_CLASSES = 10,
   parameter int IDX_W       = $clog2(NUM_CLASSES)
);
   logic                         start;
   logic [NUM_CLASSES*WIDTH-1:0] input_nums;
   logic                         busy;
   logic                         done;
   logic [IDX_W-1:0]             predicted_digit;
   logic [WIDTH-1:0]             max_value;
   logic [IDX_W-1:0]             runner_up_idx;
   logic [WIDTH:0]               margin;
   logic                         low_conf;

   modport master (
      output start, input_nums,
      input  busy, done, predicted_digit, max_value, runner_up_idx, margin, low_conf
   );

   modport slave (
      input  start, input_nums,
      output busy, done, predicted_digit, max_value, runner_up_idx, margin, low_conf
   );
endinterface

// File: rtl/argmax_top2.sv
// Multi-cycle argmax over NUM_CLASSES scores, LANES scores per cycle; reports the
// winner, runner-up, winner-to-runner-up margin and a low-confidence flag.
module argmax_top2 #(
   parameter int             WIDTH       = 32,
   parameter int             NUM_CLASSES = 10,
   parameter int             LANES       = 3,
   parameter bit             SIGNED      = 1'b0,
   parameter logic [WIDTH:0] CONF_THRESH = '0
) (
   input logic          clk,
   input logic          reset_n,
   argmax_top2_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_CLASSES);
   localparam int PTR_W = $clog2(NUM_CLASSES + LANES + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]                   state;
   logic [NUM_CLASSES*WIDTH-1:0] cap;
   logic [PTR_W-1:0]             ptr;
   logic [WIDTH-1:0]             best_v, sec_v, nb_v, ns_v, lane_v;
   logic [IDX_W-1:0]             best_i, sec_i, nb_i, ns_i, lane_i;
   logic                         best_ok, sec_ok, nb_ok, ns_ok;
   logic                         last;
   logic [WIDTH:0]               ext_b, ext_s, mrg;
   logic [WIDTH+1:0]             thr_diff;

   logic [IDX_W-1:0]             pred_q, ru_q;
   logic [WIDTH-1:0]             max_q;
   logic [WIDTH:0]               mrg_q;
   logic                         lc_q;

   function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (SIGNED) return $signed(a) > $signed(b);
      return a > b;
   endfunction

   // Lanes fold in ascending index order; strict compares keep the lower index on ties.
   always_comb begin
      nb_v   = best_v;
      nb_i   = best_i;
      nb_ok  = best_ok;
      ns_v   = sec_v;
      ns_i   = sec_i;
      ns_ok  = sec_ok;
      lane_v = '0;
      lane_i = '0;
      for (int l = 0; l < LANES; l++) begin
         if (int'(ptr) + l < NUM_CLASSES) begin
            lane_v = cap[(int'(ptr) + l)*WIDTH +: WIDTH];
            lane_i = IDX_W'(int'(ptr) + l);
            if (!nb_ok || gt(lane_v, nb_v)) begin
               if (nb_ok) begin
                  ns_v  = nb_v;
                  ns_i  = nb_i;
                  ns_ok = 1'b1;
               end
               nb_v  = lane_v;
               nb_i  = lane_i;
               nb_ok = 1'b1;
            end else if (!ns_ok || gt(lane_v, ns_v)) begin
               ns_v  = lane_v;
               ns_i  = lane_i;
               ns_ok = 1'b1;
            end
         end
      end
   end

   assign last  = (int'(ptr) + LANES >= NUM_CLASSES);
   assign ext_b = SIGNED ? {nb_v[WIDTH-1], nb_v} : {1'b0, nb_v};
   assign ext_s = SIGNED ? {ns_v[WIDTH-1], ns_v} : {1'b0, ns_v};
   assign mrg   = ext_b - ext_s;
   // Borrow out of the subtraction is exactly (mrg < CONF_THRESH).
   assign thr_diff = {1'b0, mrg} - {1'b0, CONF_THRESH};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cap     <= '0;
         ptr     <= '0;
         best_v  <= '0;
         best_i  <= '0;
         best_ok <= 1'b0;
         sec_v   <= '0;
         sec_i   <= '0;
         sec_ok  <= 1'b0;
         pred_q  <= '0;
         max_q   <= '0;
         ru_q    <= '0;
         mrg_q   <= '0;
         lc_q    <= 1'b0;
      end else begin
         case (state)
            SCAN: begin
               best_v  <= nb_v;
               best_i  <= nb_i;
               best_ok <= nb_ok;
               sec_v   <= ns_v;
               sec_i   <= ns_i;
               sec_ok  <= ns_ok;
               ptr     <= ptr + PTR_W'(LANES);
               if (last) begin
                  state  <= DONE;
                  pred_q <= nb_i;
                  max_q  <= nb_v;
                  ru_q   <= ns_i;
                  mrg_q  <= mrg;
                  lc_q   <= thr_diff[WIDTH+1];
               end
            end
            default: begin
               // IDLE and DONE both accept a new request.
               if (bus.start) begin
                  cap     <= bus.input_nums;
                  ptr     <= '0;
                  best_ok <= 1'b0;
                  sec_ok  <= 1'b0;
                  state   <= SCAN;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.busy            = (state == SCAN);
   assign bus.done            = (state == DONE);
   assign bus.predicted_digit = pred_q;
   assign bus.max_value       = max_q;
   assign bus.runner_up_idx   = ru_q;
   assign bus.margin          = mrg_q;
   assign bus.low_conf        = lc_q;
endmodule
